cdb_arbiter: RTL and testbench

- Complete-stage arbiter for the 2-way superscalar core. Shares the two CDB broadcast slots among all functional-unit result outputs.
- Category priority is BEQ > MULT > LS > ALU. Within a category, a grant-based round-robin pointer orders requesters, and per-FU age counters override priority to prevent starvation.
- Grants go back to the FUs in the same cycle so they can release their results. The broadcast FU indices are registered for the CDB/ROB/RS write stage.

---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 148 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Complete-stage bus between the functional units and the CDB arbiter.
//
// Handshake: an FU raises fu_result_valid and holds it until it sees its
// fu_grant bit high in the same cycle. The grant is combinational, the FU
// releases its result on that cycle's posedge and drops valid the next
// cycle. The grant is withheld during reset, cdb_stall or squash.
interface cdb_arbiter_if #(
  parameter int FU_SIZE = 20
);
  logic                 squash;
  logic                 cdb_stall;
  logic [FU_SIZE-1:0]   fu_result_valid;
  logic [FU_SIZE-1:0]   fu_grant;
  logic [1:0]           cdb_valid;
  logic [1:0][4:0]      cdb_fu_num;
  logic                 starve_flag;

  // FU / pipeline-control side
  modport master (
    output squash, cdb_stall, fu_result_valid,
    input  fu_grant, cdb_valid, cdb_fu_num, starve_flag
  );

  // Arbiter side
  modport slave (
    input  squash, cdb_stall, fu_result_valid,
    output fu_grant, cdb_valid, cdb_fu_num, starve_flag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-slot CDB arbiter. Starved FUs win first (lowest index), then the
// categories BEQ > MULT > LS > ALU, each ordered round-robin from its own
// pointer. Grants are combinational; slot indices are registered.
module cdb_arbiter #(
  parameter int NUM_ALU      = 8,
  parameter int NUM_LS       = 4,
  parameter int NUM_MULT     = 4,
  parameter int NUM_BEQ      = 4,
  parameter int FU_SIZE      = NUM_ALU + NUM_LS + NUM_MULT + NUM_BEQ,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  localparam int LS_BASE   = NUM_ALU;
  localparam int MULT_BASE = NUM_ALU + NUM_LS;
  localparam int BEQ_BASE  = MULT_BASE + NUM_MULT;
  // Category table in priority order: 0=BEQ, 1=MULT, 2=LS, 3=ALU
  localparam int CAT_BASE [4] = '{BEQ_BASE, MULT_BASE, LS_BASE, 0};
  localparam int CAT_N    [4] = '{NUM_BEQ, NUM_MULT, NUM_LS, NUM_ALU};
  localparam logic [3:0]         LIMIT = 4'(STARVE_LIMIT);
  localparam logic [FU_SIZE-1:0] ONE   = FU_SIZE'(1);

  logic [3:0][3:0]    r_ptr;
  logic [3:0]         r_age [FU_SIZE];
  logic [1:0]         r_cdb_valid;
  logic [1:0][4:0]    r_cdb_num;
  logic               r_starve;

  logic [FU_SIZE-1:0] w_starved;
  logic [FU_SIZE-1:0] w_at_limit;
  logic [FU_SIZE-1:0] w_rest;
  logic [FU_SIZE-1:0] w_grant;
  logic               w_en, w_f0, w_f1, w_s0, w_s1;
  logic [4:0]         w_i0, w_i1;
  logic [3:0][3:0]    w_ptr_nxt;

  // Highest-ranked requester in req: {found, global index}
  function automatic logic [5:0] pick(input logic [FU_SIZE-1:0] req,
                                      input logic [FU_SIZE-1:0] starved,
                                      input logic [3:0][3:0]    ptr);
    logic       found;
    logic [4:0] idx;
    int         j, g;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < FU_SIZE; i++) begin
      if (!found && req[i] && starved[i]) begin
        found = 1'b1;
        idx   = 5'(i);
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 16; k++) begin
        if (k < CAT_N[c]) begin
          j = int'(ptr[c]) + k;
          if (j >= CAT_N[c]) j = j - CAT_N[c];
          g = CAT_BASE[c] + j;
          if (!found && req[g] && !starved[g]) begin
            found = 1'b1;
            idx   = 5'(g);
          end
        end
      end
    end
    return {found, idx};
  endfunction

  function automatic logic in_cat(input logic [4:0] idx, input int c);
    return (int'(idx) >= CAT_BASE[c]) && (int'(idx) < CAT_BASE[c] + CAT_N[c]);
  endfunction

  // Local index one past idx inside category c, wrapping to 0
  function automatic logic [3:0] next_local(input logic [4:0] idx, input int c);
    int l;
    l = int'(idx) - CAT_BASE[c] + 1;
    if (l >= CAT_N[c]) l = 0;
    return 4'(l);
  endfunction

  // Starvation status per FU from the age counters
  always_comb begin
    w_starved  = '0;
    w_at_limit = '0;
    for (int i = 0; i < FU_SIZE; i++) begin
      w_at_limit[i] = (r_age[i] == LIMIT);
      w_starved[i]  = bus.fu_result_valid[i] && (r_age[i] == LIMIT);
    end
  end

  // Slot 0 / slot 1 selection and the combinational grant vector
  always_comb begin
    w_en          = reset && !bus.cdb_stall && !bus.squash;
    {w_f0, w_i0}  = pick(bus.fu_result_valid, w_starved, r_ptr);
    w_rest        = bus.fu_result_valid & ~(ONE << w_i0);
    {w_f1, w_i1}  = pick(w_rest, w_starved, r_ptr);
    w_s0          = w_en && w_f0;
    w_s1          = w_en && w_f1;
    w_grant       = '0;
    if (w_s0) w_grant = w_grant | (ONE << w_i0);
    if (w_s1) w_grant = w_grant | (ONE << w_i1);
  end

  assign bus.fu_grant    = w_grant;
  assign bus.cdb_valid   = r_cdb_valid;
  assign bus.cdb_fu_num  = r_cdb_num;
  assign bus.starve_flag = r_starve;

  // Round-robin pointers move past the last winner of their category
  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int c = 0; c < 4; c++) begin
      if (w_s0 && in_cat(w_i0, c)) w_ptr_nxt[c] = next_local(w_i0, c);
      if (w_s1 && in_cat(w_i1, c)) w_ptr_nxt[c] = next_local(w_i1, c);
    end
  end

  // Age counters: squash clears, stall freezes, otherwise count waiting cycles
  always_ff @(posedge clock) begin
    if (!reset || bus.squash) begin
      for (int i = 0; i < FU_SIZE; i++) r_age[i] <= '0;
    end else if (!bus.cdb_stall) begin
      for (int i = 0; i < FU_SIZE; i++) begin
        if (w_grant[i] || !bus.fu_result_valid[i]) r_age[i] <= '0;
        else if (r_age[i] != LIMIT)                 r_age[i] <= r_age[i] + 4'd1;
      end
    end
  end

  // Registered broadcast slots, pointers and starvation flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_cdb_valid <= '0;
      r_cdb_num   <= '0;
      r_starve    <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_starve    <= |w_at_limit;
      r_cdb_valid <= {w_s1, w_s0};
      if (w_s0) r_cdb_num[0] <= w_i0;
      if (w_s1) r_cdb_num[1] <= w_i1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter with hand-computed vectors.
module tb_cdb_arbiter;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  cdb_arbiter_if #(.FU_SIZE(20)) bus ();

  cdb_arbiter #(
    .NUM_ALU(8), .NUM_LS(4), .NUM_MULT(4), .NUM_BEQ(4),
    .FU_SIZE(20), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [19:0] valid;
    logic        stall;
    logic        squash;
    logic [19:0] grant;
    logic [1:0]  cv;
    logic [4:0]  n0;
    logic [4:0]  n1;
    logic        sf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [19:0] valid, input logic stall, input logic squash,
                     input logic [19:0] grant, input logic [1:0] cv,
                     input logic [4:0] n0, input logic [4:0] n1, input logic sf);
    vec_t v;
    v.valid = valid; v.stall = stall; v.squash = squash; v.grant = grant;
    v.cv = cv; v.n0 = n0; v.n1 = n1; v.sf = sf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=0x%0h expected=0x%0h", name, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the posedge
  task automatic drive(input logic [19:0] valid, input logic stall, input logic squash);
    @(posedge clock);
    #1;
    bus.fu_result_valid = valid;
    bus.cdb_stall       = stall;
    bus.squash          = squash;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.fu_result_valid = 20'hFFFFF;
    bus.cdb_stall       = 1'b0;
    bus.squash          = 1'b0;

    // Reset held with every FU requesting: no grants, slots cleared
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
      check("reset_grant", c, 32'(bus.fu_grant), 32'h0);
      check("reset_cdb_valid", c, 32'(bus.cdb_valid), 32'h0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.fu_result_valid = '0;
    @(negedge clock);
    check("post_reset_cdb_valid", 0, 32'(bus.cdb_valid), 32'h0);
    check("post_reset_starve", 0, 32'(bus.starve_flag), 32'h0);

    // valid, stall, squash, grant, cdb_valid, num0, num1, starve
    // Mixed categories {0,9,13,17}: BEQ then MULT
    add(20'h22201, 0, 0, 20'h22000, 2'b00,  0,  0, 0);
    add(20'h00000, 0, 0, 20'h00000, 2'b11, 17, 13, 0);
    add(20'h00000, 0, 0, 20'h00000, 2'b00, 17, 13, 0);
    // All ALUs held valid: pairs walk the pointer and wrap
    add(20'h000FF, 0, 0, 20'h00003, 2'b00, 17, 13, 0);
    add(20'h000FF, 0, 0, 20'h0000C, 2'b11,  0,  1, 0);
    add(20'h000FF, 0, 0, 20'h00030, 2'b11,  2,  3, 0);
    add(20'h000FF, 0, 0, 20'h000C0, 2'b11,  4,  5, 0);
    add(20'h000FF, 0, 0, 20'h00003, 2'b11,  6,  7, 0);
    add(20'h00000, 0, 0, 20'h00000, 2'b11,  0,  1, 0);
    // BEQ 16,17 hog both slots until ALU 3 starves
    add(20'h30008, 0, 0, 20'h30000, 2'b00,  0,  1, 0);
    add(20'h30008, 0, 0, 20'h30000, 2'b11, 16, 17, 0);
    add(20'h30008, 0, 0, 20'h30000, 2'b11, 16, 17, 0);
    add(20'h30008, 0, 0, 20'h30000, 2'b11, 16, 17, 0);
    add(20'h30008, 0, 0, 20'h10008, 2'b11, 16, 17, 0);
    add(20'h30000, 0, 0, 20'h30000, 2'b11,  3, 16, 1);
    add(20'h00000, 0, 0, 20'h00000, 2'b11, 17, 16, 0);
    // Stall two cycles with {12,18}: no grant, indices hold
    add(20'h41000, 1, 0, 20'h00000, 2'b00, 17, 16, 0);
    add(20'h41000, 1, 0, 20'h00000, 2'b00, 17, 16, 0);
    add(20'h41000, 0, 0, 20'h41000, 2'b00, 17, 16, 0);
    add(20'h00000, 0, 0, 20'h00000, 2'b11, 18, 12, 0);
    // ALU 1 ages three cycles, squash clears it; BEQ pointer must not move
    add(20'h30002, 0, 0, 20'h30000, 2'b00, 18, 12, 0);
    add(20'h30002, 0, 0, 20'h30000, 2'b11, 16, 17, 0);
    add(20'h30002, 0, 0, 20'h30000, 2'b11, 16, 17, 0);
    add(20'h80002, 0, 1, 20'h00000, 2'b11, 16, 17, 0);
    add(20'hF0002, 0, 0, 20'hC0000, 2'b00, 16, 17, 0);
    add(20'hF0002, 0, 0, 20'h30000, 2'b11, 18, 19, 0);
    add(20'hF0002, 0, 0, 20'hC0000, 2'b11, 16, 17, 0);
    add(20'hF0002, 0, 0, 20'h30000, 2'b11, 18, 19, 0);
    add(20'hF0002, 0, 0, 20'h40002, 2'b11, 16, 17, 0);
    add(20'hF0000, 0, 0, 20'h90000, 2'b11,  1, 18, 1);
    add(20'h00000, 0, 0, 20'h00000, 2'b11, 19, 16, 0);
    add(20'h00000, 0, 0, 20'h00000, 2'b00, 19, 16, 0);

    foreach (vecs[r]) begin
      drive(vecs[r].valid, vecs[r].stall, vecs[r].squash);
      @(negedge clock);
      check("fu_grant",    r, 32'(bus.fu_grant),      32'(vecs[r].grant));
      check("cdb_valid",   r, 32'(bus.cdb_valid),     32'(vecs[r].cv));
      check("cdb_fu_num0", r, 32'(bus.cdb_fu_num[0]), 32'(vecs[r].n0));
      check("cdb_fu_num1", r, 32'(bus.cdb_fu_num[1]), 32'(vecs[r].n1));
      check("starve_flag", r, 32'(bus.starve_flag),   32'(vecs[r].sf));
    end

    // Squash together with stall still clears ages: age ALU 0 for three
    // cycles, hit both, then ALU 0 must wait four full cycles before winning.
    for (int c = 0; c < 3; c++) begin
      drive(20'h30001, 0, 0);
      @(negedge clock);
      check("sqst_pre_grant", c, 32'(bus.fu_grant), 32'h30000);
    end
    drive(20'h30001, 1, 1);
    @(negedge clock);
    check("sqst_grant", 0, 32'(bus.fu_grant), 32'h0);
    for (int c = 0; c < 4; c++) begin
      drive(20'h30001, 0, 0);
      @(negedge clock);
      if (c == 0) check("sqst_cdb_valid", c, 32'(bus.cdb_valid), 32'h0);
      check("sqst_post_grant", c, 32'(bus.fu_grant), 32'h30000);
    end
    drive(20'h30001, 0, 0);
    @(negedge clock);
    check("sqst_alu0_wins", 0, 32'(bus.fu_grant[0]), 32'h1);
    check("sqst_popcount", 0, 32'($countones(bus.fu_grant)), 32'h2);

    drive(20'h00000, 0, 0);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
